// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer with a one-word output holding register.
// Realigns on frame_start; flags dropped words with a sticky overrun bit.
module sipo_deser #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sin,
    input  logic                       sin_valid,
    input  logic                       frame_start,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       overrun,
    input  logic                       ovr_clr,
    output logic [$clog2(WIDTH):0]     bit_cnt
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dval_q, dval_d;
    logic             ovr_q, ovr_d;

    logic [WIDTH-1:0] base_s;
    logic [CW-1:0]    base_c;
    logic [WIDTH-1:0] shifted;
    logic             complete;

    // Next-state: realign, shift, word hand-off and overrun tracking.
    always_comb begin
        base_s   = frame_start ? '0 : sreg_q;
        base_c   = frame_start ? '0 : cnt_q;
        shifted  = MSB_FIRST ? {base_s[WIDTH-2:0], sin}
                             : {sin, base_s[WIDTH-1:1]};
        complete = sin_valid && (base_c == LAST);
        sreg_d   = base_s;
        cnt_d    = base_c;
        dout_d   = dout_q;
        dval_d   = dval_q;
        ovr_d    = ovr_clr ? 1'b0 : ovr_q;
        if (sin_valid) begin
            sreg_d = shifted;
            cnt_d  = complete ? '0 : base_c + 1'b1;
        end
        if (complete) begin
            if (!dval_q || dout_ready) begin
                dout_d = shifted;
                dval_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (dval_q && dout_ready) begin
            dval_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            dval_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            dval_q <= dval_d;
            ovr_q  <= ovr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dval_q;
    assign overrun    = ovr_q;
    assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances driven in parallel,
// checked against a bit-queue model every cycle plus literal expectations.
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rst, sin, sin_valid, frame_start, dout_ready, ovr_clr;
    logic [3:0] dout_m, dout_l;
    logic       dv_m, dv_l, ovr_m, ovr_l;
    logic [2:0] bc_m, bc_l;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model state
    bit         mq[$];
    logic [3:0] m_dm, m_dl;
    bit         m_val, m_ovr;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) u_m (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
        .frame_start(frame_start), .dout(dout_m), .dout_valid(dv_m),
        .dout_ready(dout_ready), .overrun(ovr_m), .ovr_clr(ovr_clr),
        .bit_cnt(bc_m)
    );

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) u_l (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
        .frame_start(frame_start), .dout(dout_l), .dout_valid(dv_l),
        .dout_ready(dout_ready), .overrun(ovr_l), .ovr_clr(ovr_clr),
        .bit_cnt(bc_l)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: collect bits in arrival order, form the word when full.
    task automatic model_step();
        bit comp = 0;
        bit drop = 0;
        logic [3:0] wm = '0;
        logic [3:0] wl = '0;
        if (rst) begin
            mq.delete();
            m_dm = '0; m_dl = '0; m_val = 0; m_ovr = 0;
            return;
        end
        if (frame_start) mq.delete();
        if (sin_valid) begin
            mq.push_back(sin);
            if (mq.size() == 4) begin
                for (int i = 0; i < 4; i++) begin
                    wm[3-i] = mq[i];
                    wl[i]   = mq[i];
                end
                mq.delete();
                comp = 1;
            end
        end
        if (comp) begin
            if (!m_val || dout_ready) begin
                m_dm = wm; m_dl = wl; m_val = 1;
            end else begin
                drop = 1;
            end
        end else if (m_val && dout_ready) begin
            m_val = 0;
        end
        if (ovr_clr) m_ovr = 0;
        if (drop) m_ovr = 1;
    endtask

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", dv_m, m_val);
            chk("l_valid", dv_l, m_val);
            chk("m_ovr", ovr_m, m_ovr);
            chk("l_ovr", ovr_l, m_ovr);
            chk("m_cnt", bc_m, mq.size());
            chk("l_cnt", bc_l, mq.size());
            chk("m_dout", dout_m, m_dm);
            chk("l_dout", dout_l, m_dl);
        end
    end

    task automatic cyc(input logic sv, input logic s, input logic fs,
                       input logic rdy, input logic oc, input logic r);
        sin_valid = sv; sin = s; frame_start = fs;
        dout_ready = rdy; ovr_clr = oc; rst = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Send four bits w[3]..w[0]; ready/clear apply only to the last edge.
    task automatic word(input logic [3:0] w, input logic rdy_last,
                        input logic oc_last);
        for (int i = 3; i > 0; i--) cyc(1, w[i], 0, 0, 0, 0);
        cyc(1, w[0], 0, rdy_last, oc_last, 0);
    endtask

    initial begin
        rst = 1; sin = 0; sin_valid = 0; frame_start = 0;
        dout_ready = 0; ovr_clr = 0;
        @(negedge clk);
        cyc(0, 0, 0, 0, 0, 1);
        chk_en = 1;
        chk("rst_valid", dv_m, 0);
        chk("rst_ovr", ovr_m, 0);
        chk("rst_cnt", bc_m, 0);
        chk("rst_dout", dout_m, 0);

        // 1,0,1,1
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("cnt3", bc_m, 3);
        cyc(1, 1, 0, 0, 0, 0);
        chk("msb_1011", dout_m, 4'b1011);
        chk("lsb_1101", dout_l, 4'b1101);
        chk("lat_valid", dv_m, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("hold_valid", dv_m, 1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("drain", dv_m, 0);
        chk("drain_dout", dout_m, 4'b1011);
        cyc(0, 0, 0, 1, 0, 0);

        // overrun
        word(4'hA, 0, 0);
        chk("wordA", dout_m, 4'hA);
        word(4'h5, 0, 0);
        chk("keepA", dout_m, 4'hA);
        chk("ovr_set", ovr_m, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("ovr_sticky", ovr_m, 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("ovr_clr", ovr_m, 0);
        word(4'h9, 0, 1);
        chk("ovr_wins", ovr_m, 1);
        cyc(0, 0, 0, 1, 1, 0);
        chk("ovr_clr2", ovr_m, 0);

        // back-to-back with ready on completion
        word(4'h3, 1, 0);
        chk("w3", dout_m, 4'h3);
        word(4'hC, 1, 0);
        chk("wC", dout_m, 4'hC);
        chk("wC_valid", dv_m, 1);
        chk("wC_ovr", ovr_m, 0);
        cyc(0, 0, 0, 1, 0, 0);

        // frame_start realign
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        chk("fs_cnt1", bc_m, 1);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("fs_F", dout_m, 4'hF);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("fs_cnt0", bc_m, 0);

        // reset mid-word
        cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("rst2_valid", dv_m, 0);
        chk("rst2_ovr", ovr_m, 0);
        chk("rst2_cnt", bc_m, 0);
        word(4'h6, 0, 0);
        chk("w6_m", dout_m, 4'h6);
        chk("w6_l", dout_l, 4'h6);
        cyc(0, 0, 0, 0, 0, 0);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first received bit lands in dout[WIDTH-1]; 0 = first received bit lands in dout[0].
REQ-003 clk  input  1  clock; every register updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sin  input  1  serial data bit; sampled only when sin_valid=1.
REQ-006 sin_valid  input  1  bit strobe; a high level on an edge shifts sin in.
REQ-007 frame_start  input  1  realign pulse; discards any partial word.
REQ-008 dout  output  WIDTH  last completed parallel word.
REQ-009 dout_valid  output  1  dout holds an unread word.
REQ-010 dout_ready  input  1  consumer accepts dout when dout_valid=1 and dout_ready=1.
REQ-011 overrun  output  1  sticky: a completed word was dropped.
REQ-012 ovr_clr  input  1  clears overrun.
REQ-013 bit_cnt  output  clog2(WIDTH)+1  bits held in the partial word (0..WIDTH-1).

Function
REQ-014 Internal shift register sreg[WIDTH-1:0] and counter cnt; on each sin_valid=1 edge, sin is shifted in and cnt increments by 1.
REQ-015 MSB_FIRST=1 shifts left: sreg <= {sreg[WIDTH-2:0], sin}.
REQ-016 MSB_FIRST=0 shifts right: sreg <= {sin, sreg[WIDTH-1:1]}.
REQ-017 Word completion is the sin_valid edge with cnt=WIDTH-1; on that edge, cnt wraps to 0.
REQ-018 On completion, the next-state shift value, including the current sin, is the completed word.
REQ-019 On completion with dout_valid=0, or with dout_valid=1 and dout_ready=1, dout is loaded with the completed word and dout_valid is 1 after the edge.
REQ-020 Latency: dout_valid rises on the same edge that samples the last bit, with no extra pipeline cycle.
REQ-021 On completion with dout_valid=1 and dout_ready=0, the new word is dropped, dout and dout_valid are unchanged, and overrun is set to 1.
REQ-022 With no completion on an edge, dout_valid=1 and dout_ready=1 clear dout_valid to 0 and leave dout unchanged.
REQ-023 dout_valid=0 with dout_ready=1 has no effect.
REQ-024 dout is stable while dout_valid=1.
REQ-025 frame_start=1 with sin_valid=0 sets cnt to 0 and clears sreg.
REQ-026 frame_start=1 with sin_valid=1 treats sin as bit 0 of a new word and sets cnt to 1.
REQ-027 frame_start does not affect dout, dout_valid or overrun.
REQ-028 overrun stays 1 until an edge with ovr_clr=1.
REQ-029 If ovr_clr=1 and a new overrun occur on the same edge, the new overrun wins and overrun stays 1.
REQ-030 sin_valid=0 holds sreg and cnt, with no timeout.
REQ-031 bit_cnt equals cnt.

Reset
REQ-032 When rst=1 on an edge: sreg=0, cnt=0, dout=0, dout_valid=0, overrun=0; rst overrides every other input.
REQ-033 rst asserted mid-word discards the partial word; the next sin_valid after reset is bit 0.
REQ-034 Outputs are undefined only before the first edge with rst=1.

Verification
REQ-035 WIDTH=4, MSB_FIRST=1, sin=1,0,1,1 on four consecutive sin_valid edges -> dout=4'b1011 and dout_valid=1 on the 4th edge; dout_valid stays high until dout_ready=1.
REQ-036 MSB_FIRST=0, same bit stream -> dout=4'b1101.
REQ-037 Word A=4'hA is complete and unread, then word B=4'h5 completes with dout_ready=0 -> dout stays 4'hA and overrun=1; an ovr_clr pulse -> overrun=0.
REQ-038 Back-to-back words with dout_ready=1 on each completion edge -> dout_valid never drops, dout steps 4'h3 then 4'hC, and overrun stays 0.
REQ-039 Two bits sent, then frame_start with sin_valid=1 and sin=1, then 1,1,1 -> bit_cnt=1 after the frame_start edge and dout=4'hF.
REQ-040 rst after two bits, then bits 0,1,1,0 -> dout=4'h6 with no residue from the bits sent before reset; dout_valid=0 and overrun=0 immediately after the reset edge.
